gray_fifo_bridge: RTL and testbench

GRAY_FIFO_BRIDGE -- requirements
Module: gray_fifo_bridge

---
 rtl/gray_fifo_bridge_if.sv | 38 +++
 rtl/gray_fifo_bridge.sv | 106 ++++++++++
 tb/tb_gray_fifo_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_fifo_bridge_if.sv
// gray_fifo_bridge_if
//   Groups the upstream (first-word-fall-through read side) and downstream
//   (write side) FIFO handshake signals used by gray_fifo_bridge.
//   master modport: the bridge (pops upstream, pushes downstream).
//   slave  modport: the FIFOs / environment around the bridge.
//
//   in_dout   [23:0] RGB pixel from upstream FIFO, R[23:16] G[15:8] B[7:0]
//   in_empty         upstream FIFO empty
//   in_rd_en         pop upstream FIFO
//   out_din   [7:0]  grayscale pixel to downstream FIFO
//   out_full         downstream FIFO full
//   out_wr_en        push downstream FIFO
interface gray_fifo_bridge_if;
    logic [23:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [7:0]  out_din;
    logic        out_full;
    logic        out_wr_en;

    modport master (
        input  in_dout,
        input  in_empty,
        input  out_full,
        output in_rd_en,
        output out_din,
        output out_wr_en
    );

    modport slave (
        output in_dout,
        output in_empty,
        output out_full,
        input  in_rd_en,
        input  out_din,
        input  out_wr_en
    );
endinterface

// File: rtl/gray_fifo_bridge.sv
// gray_fifo_bridge
//   Pops RGB pixels from a first-word-fall-through FIFO, converts each to an
//   8-bit grayscale value and pushes it into a downstream FIFO. One pixel per
//   two clocks at best; back-pressure holds the pixel with no loss. Counts
//   pixels written per frame and pulses frame_done after the last one.
//
//   Build option: define GRAYSCALE_LUMA_EN for weighted luma
//   (77R + 150G + 29B) >> 8; otherwise the plain average (R + G + B) / 3.
//
//   Ports
//     clock        single clock
//     reset        asynchronous, active-high
//     fifo         gray_fifo_bridge_if.master handshake bundle
//     pixel_count  pixels written in the current frame
//     frame_done   one-cycle pulse after the last pixel of a frame
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_READ  | waiting for upstream data; pops and latches when non-empty
//   S_WRITE | holding rgb_reg; pushes its grayscale when downstream ready
module gray_fifo_bridge #(
    parameter int FRAME_PIXELS = 388800,
    parameter int CNT_WIDTH    = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    gray_fifo_bridge_if.master   fifo,
    output logic [CNT_WIDTH-1:0] pixel_count,
    output logic                 frame_done
);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_PIXEL = CNT_WIDTH'(FRAME_PIXELS - 1);

    state_t      state;
    logic [23:0] rgb_reg;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [7:0]  gray;

    assign red   = rgb_reg[23:16];
    assign green = rgb_reg[15:8];
    assign blue  = rgb_reg[7:0];

`ifdef GRAYSCALE_LUMA_EN
    // Weights sum to 256, so 255 * 256 is the largest value: fits 16 bits.
    logic [15:0] luma_sum;
    always_comb begin
        luma_sum = 16'd77  * {8'h00, red}
                 + 16'd150 * {8'h00, green}
                 + 16'd29  * {8'h00, blue};
        gray     = 8'(luma_sum >> 8);
    end
`else
    logic [9:0] avg_sum;
    always_comb begin
        avg_sum = {2'b00, red} + {2'b00, green} + {2'b00, blue};
        gray    = 8'(avg_sum / 10'd3);
    end
`endif

    assign fifo.out_din = gray;

    // Handshakes are combinational on the FIFO flags so a pop and the
    // following push are back to back; reset forces both low.
    always_comb begin
        fifo.in_rd_en  = !reset && (state == S_READ)  && !fifo.in_empty;
        fifo.out_wr_en = !reset && (state == S_WRITE) && !fifo.out_full;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_READ;
            rgb_reg     <= '0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_READ: begin
                    if (!fifo.in_empty) begin
                        rgb_reg <= fifo.in_dout;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!fifo.out_full) begin
                        state <= S_READ;
                        if (pixel_count == LAST_PIXEL) begin
                            pixel_count <= '0;
                            frame_done  <= 1'b1;
                        end else begin
                            pixel_count <= pixel_count + CNT_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_fifo_bridge.sv
module tb_gray_fifo_bridge;

    localparam int FP  = 4;
    localparam int CW  = 3;
`ifdef GRAYSCALE_LUMA_EN
    localparam logic [7:0] SAMPLE_GRAY = 8'h63;
`else
    localparam logic [7:0] SAMPLE_GRAY = 8'h6A;
`endif

    logic          clock;
    logic          reset;
    logic [CW-1:0] pixel_count;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    gray_fifo_bridge_if bus ();

    gray_fifo_bridge #(
        .FRAME_PIXELS (FP),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fifo        (bus),
        .pixel_count (pixel_count),
        .frame_done  (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] ref_gray(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef GRAYSCALE_LUMA_EN
        return 8'((77 * r + 150 * g + 29 * b) / 256);
`else
        return 8'((r + g + b) / 3);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_empty = 1'b0;
        bus.in_dout  = 24'h123456;
        bus.out_full = 1'b0;
        #2;
        chk("rst_rd_en", 32'(bus.in_rd_en), 0);
        chk("rst_wr_en", 32'(bus.out_wr_en), 0);
        chk("rst_count", 32'(pixel_count), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        repeat (2) step();
        chk("rst_rd_en_hold", 32'(bus.in_rd_en), 0);
        reset        = 1'b0;
        bus.in_empty = 1'b1;
        step();
    endtask

    // Pop one pixel, push it, then look at the counter one cycle later.
    task automatic push_one(input logic [23:0] pix, input logic [7:0] exp_gray,
                            input int exp_cnt, input logic exp_fd);
        bus.in_dout  = pix;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b0;
        @(negedge clock);
        chk("push_rd", 32'(bus.in_rd_en), 1);
        chk("push_wr_idle", 32'(bus.out_wr_en), 0);
        chk("push_fd_low", 32'(frame_done), 0);
        step();
        bus.in_empty = 1'b1;
        @(negedge clock);
        chk("push_wr", 32'(bus.out_wr_en), 1);
        chk("push_rd_idle", 32'(bus.in_rd_en), 0);
        chk("push_din", 32'(bus.out_din), 32'(exp_gray));
        step();
        @(negedge clock);
        chk("push_count", 32'(pixel_count), 32'(exp_cnt));
        chk("push_frame_done", 32'(frame_done), 32'(exp_fd));
        chk("push_wr_after", 32'(bus.out_wr_en), 0);
        step();
    endtask

    // Random-phase model: the bridge holds at most one pixel (queue held_q).
    logic [7:0]  held_q[$];
    logic [23:0] cur_pix;
    int          n_wr;
    logic        fd_pend;

    initial begin
        reset        = 1'b1;
        bus.in_dout  = '0;
        bus.in_empty = 1'b1;
        bus.out_full = 1'b0;
        step();
        do_reset();

        // sample pixel, extremes, and a frame wrap: counts 1,2,3,0,1
        push_one(24'h3C6E96, SAMPLE_GRAY, 1, 1'b0);
        push_one(24'hFFFFFF, 8'hFF,       2, 1'b0);
        push_one(24'h000000, 8'h00,       3, 1'b0);
        push_one(24'h3C6E96, SAMPLE_GRAY, 0, 1'b1);
        push_one(24'hFFFFFF, 8'hFF,       1, 1'b0);

        // back-pressure for 10 cycles with more data waiting upstream
        bus.in_dout  = 24'h3C6E96;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b1;
        @(negedge clock);
        chk("bp_pop", 32'(bus.in_rd_en), 1);
        step();
        bus.in_dout = 24'hFFFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("bp_wr_low", 32'(bus.out_wr_en), 0);
            chk("bp_rd_low", 32'(bus.in_rd_en), 0);
            chk("bp_din_stable", 32'(bus.out_din), 32'(SAMPLE_GRAY));
            step();
        end
        bus.out_full = 1'b0;
        @(negedge clock);
        chk("bp_release_wr", 32'(bus.out_wr_en), 1);
        chk("bp_release_din", 32'(bus.out_din), 32'(SAMPLE_GRAY));
        step();
        bus.in_empty = 1'b1;
        @(negedge clock);
        chk("bp_single_write", 32'(bus.out_wr_en), 0);
        chk("bp_count", 32'(pixel_count), 2);
        step();

        // reset while holding a pixel in S_WRITE
        bus.in_dout  = 24'hFFFFFF;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b1;
        @(negedge clock);
        chk("mid_pop", 32'(bus.in_rd_en), 1);
        step();
        bus.in_empty = 1'b1;
        @(negedge clock);
        chk("mid_held", 32'(bus.out_wr_en), 0);
        #1;
        bus.out_full = 1'b0;
        reset        = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(bus.out_wr_en), 0);
        chk("mid_rst_rd", 32'(bus.in_rd_en), 0);
        chk("mid_rst_count", 32'(pixel_count), 0);
        chk("mid_rst_fd", 32'(frame_done), 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_discard", 32'(bus.out_wr_en), 0);
        step();
        push_one(24'h3C6E96, SAMPLE_GRAY, 1, 1'b0);

        // randomized stream against the queue model
        do_reset();
        n_wr    = 0;
        fd_pend = 1'b0;
        cur_pix = 24'($urandom);
        held_q.delete();
        bus.in_dout  = cur_pix;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b0;
        for (int cyc = 0; cyc < 20000 && n_wr < 1000; cyc++) begin
            logic exp_rd, exp_wr;
            @(negedge clock);
            exp_rd = (held_q.size() == 0) && !bus.in_empty;
            exp_wr = (held_q.size() != 0) && !bus.out_full;
            chk("rnd_rd_en", 32'(bus.in_rd_en), 32'(exp_rd));
            chk("rnd_wr_en", 32'(bus.out_wr_en), 32'(exp_wr));
            chk("rnd_count", 32'(pixel_count), 32'(n_wr % FP));
            chk("rnd_frame_done", 32'(frame_done), 32'(fd_pend));
            fd_pend = 1'b0;
            if (exp_wr) begin
                chk("rnd_din", 32'(bus.out_din), 32'(held_q[0]));
                void'(held_q.pop_front());
                n_wr++;
                fd_pend = ((n_wr % FP) == 0);
            end
            if (exp_rd)
                held_q.push_back(ref_gray(cur_pix));
            step();
            if (exp_rd)
                cur_pix = 24'($urandom);
            bus.in_empty = ($urandom_range(0, 1) == 0);
            bus.out_full = ($urandom_range(0, 9) < 3);
            bus.in_dout  = bus.in_empty ? 24'($urandom) : cur_pix;
        end
        chk("rnd_pixels_written", 32'(n_wr), 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
